// File: rtl/ttt_pkg.sv
// Encodings shared by the tic-tac-toe control FSM, the display path and the match scoreboard.
// Also holds the helper that maps a match winner to its status digit.
package ttt_pkg;

    typedef enum logic [1:0] {
        W_NONE = 2'b00,
        W_X    = 2'b01,
        W_O    = 2'b10,
        W_DRAW = 2'b11
    } winner_e;

    typedef enum logic [1:0] {
        S_PLAY  = 2'b00,
        S_HOLD  = 2'b01,
        S_MATCH = 2'b10
    } state_e;

    localparam logic [3:0] STATUS_PLAYING = 4'd0;
    localparam logic [3:0] STATUS_X_MATCH = 4'd1;
    localparam logic [3:0] STATUS_O_MATCH = 4'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] status_nibble(input logic [1:0] match_winner);
        logic [3:0] status;
        case (match_winner)
            W_X:     status = STATUS_X_MATCH;
            W_O:     status = STATUS_O_MATCH;
            default: status = STATUS_PLAYING;
        endcase
        return status;
    endfunction

endpackage

// File: rtl/bcd_tally.sv
// Single BCD digit counter that saturates at 9; a clear wins over an increment.
module bcd_tally
    import ttt_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] count_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (inc_i && (count_q != BCD_MAX)) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/match_scoreboard_chk.sv
// Structural invariants of the scoreboard outputs: legal BCD digits and a consistent match flag.
module match_scoreboard_chk (
    input logic        clk_i,
    input logic        rst_ni,
    input logic        match_over_i,
    input logic [1:0]  match_winner_i,
    input logic [15:0] score_i
);

    a_x_digit:   assert property (@(posedge clk_i) disable iff (!rst_ni) score_i[3:0]   <= 4'd9);
    a_o_digit:   assert property (@(posedge clk_i) disable iff (!rst_ni) score_i[7:4]   <= 4'd9);
    a_d_digit:   assert property (@(posedge clk_i) disable iff (!rst_ni) score_i[11:8]  <= 4'd9);
    a_status:    assert property (@(posedge clk_i) disable iff (!rst_ni) score_i[15:12] <= 4'd2);
    a_mw_legal:  assert property (@(posedge clk_i) disable iff (!rst_ni) match_winner_i != 2'b11);
    a_over_flag: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  match_over_i == (match_winner_i != 2'b00));

endmodule

// File: rtl/match_scoreboard.sv
// Match-level scorekeeper: counts X/O/draw results, declares a best-of match winner,
// and requests the next game after a hold delay.
module match_scoreboard
    import ttt_pkg::*;
#(
    parameter int WIN_TARGET  = 3,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  winner,
    input  logic        clear,
    output logic        new_game,
    output logic        match_over,
    output logic [1:0]  match_winner,
    output logic [15:0] score_data
);

    localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       TARGET_M1 = 4'(WIN_TARGET - 1);

    state_e           state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [1:0]       winner_q;
    logic             new_game_q;
    logic             match_over_q;
    logic [1:0]       match_winner_q;

    logic [3:0] x_cnt_s;
    logic [3:0] o_cnt_s;
    logic [3:0] d_cnt_s;

    logic game_end_s;
    logic accept_s;
    logic inc_x_s;
    logic inc_o_s;
    logic inc_d_s;
    logic x_hit_s;
    logic o_hit_s;

    // A result only counts on its first cycle, only in PLAY, and never alongside a clear.
    always_comb begin
        game_end_s = (winner_q == W_NONE) && (winner != W_NONE);
        accept_s   = game_end_s && (state_q == S_PLAY) && !clear;
        inc_x_s    = accept_s && (winner == W_X);
        inc_o_s    = accept_s && (winner == W_O);
        inc_d_s    = accept_s && (winner == W_DRAW);
        x_hit_s    = inc_x_s && (x_cnt_s == TARGET_M1);
        o_hit_s    = inc_o_s && (o_cnt_s == TARGET_M1);
    end

    bcd_tally u_x_tally (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (clear),
        .inc_i   (inc_x_s),
        .count_o (x_cnt_s)
    );

    bcd_tally u_o_tally (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (clear),
        .inc_i   (inc_o_s),
        .count_o (o_cnt_s)
    );

    bcd_tally u_d_tally (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (clear),
        .inc_i   (inc_d_s),
        .count_o (d_cnt_s)
    );

    // Match FSM with hold counter and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_PLAY;
            hold_cnt_q     <= {CNT_W{1'b0}};
            winner_q       <= 2'b00;
            new_game_q     <= 1'b0;
            match_over_q   <= 1'b0;
            match_winner_q <= 2'b00;
        end else begin
            winner_q   <= winner;
            new_game_q <= 1'b0;
            if (clear) begin
                state_q        <= S_PLAY;
                hold_cnt_q     <= {CNT_W{1'b0}};
                new_game_q     <= 1'b1;
                match_over_q   <= 1'b0;
                match_winner_q <= 2'b00;
            end else begin
                case (state_q)
                    S_PLAY: begin
                        if (x_hit_s) begin
                            state_q        <= S_MATCH;
                            match_over_q   <= 1'b1;
                            match_winner_q <= W_X;
                        end else if (o_hit_s) begin
                            state_q        <= S_MATCH;
                            match_over_q   <= 1'b1;
                            match_winner_q <= W_O;
                        end else if (accept_s) begin
                            state_q    <= S_HOLD;
                            hold_cnt_q <= HOLD_LOAD;
                        end else begin
                            state_q <= S_PLAY;
                        end
                    end
                    S_HOLD: begin
                        if (hold_cnt_q == {CNT_W{1'b0}}) begin
                            state_q    <= S_PLAY;
                            new_game_q <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - CNT_W'(1'b1);
                        end
                    end
                    S_MATCH: begin
                        state_q <= S_MATCH;
                    end
                    default: begin
                        state_q    <= S_PLAY;
                        hold_cnt_q <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign new_game     = new_game_q;
    assign match_over   = match_over_q;
    assign match_winner = match_winner_q;
    assign score_data   = {status_nibble(match_winner_q), d_cnt_s, o_cnt_s, x_cnt_s};

    match_scoreboard_chk u_chk (
        .clk_i          (clk),
        .rst_ni         (reset),
        .match_over_i   (match_over_q),
        .match_winner_i (match_winner_q),
        .score_i        (score_data)
    );

endmodule

// File: tb/tb_match_scoreboard.sv
// Self-checking bench for match_scoreboard: directed scenarios plus a randomized run
// compared against a timestamp-based reference model.
module tb_match_scoreboard;

    localparam int HOLD   = 4;
    localparam int TARGET = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  winner;
    logic        clear;
    logic        new_game;
    logic        match_over;
    logic [1:0]  match_winner;
    logic [15:0] score_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ng_seen  = 0;

    // Reference model: tallies, match winner, earliest cycle a new result is accepted,
    // and the cycle whose post-edge sample must show new_game.
    int   m_x, m_o, m_d, m_mw, m_ready, m_ng_due, m_prev;
    logic m_ng;

    always #5 clk = ~clk;

    match_scoreboard #(
        .WIN_TARGET  (TARGET),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .winner       (winner),
        .clear        (clear),
        .new_game     (new_game),
        .match_over   (match_over),
        .match_winner (match_winner),
        .score_data   (score_data)
    );

    task automatic model_reset();
        m_x = 0; m_o = 0; m_d = 0; m_mw = 0;
        m_ready = 0; m_ng_due = -1; m_prev = 0; m_ng = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] w, input logic c);
        bit ev;
        ev     = (m_prev == 0) && (w != 2'b00);
        m_prev = int'(w);
        m_ng   = 1'b0;
        if (c) begin
            m_x = 0; m_o = 0; m_d = 0; m_mw = 0;
            m_ready = cyc + 1; m_ng_due = -1; m_ng = 1'b1;
        end else begin
            if (m_ng_due == cyc) begin
                m_ng = 1'b1;
                m_ng_due = -1;
            end
            if (ev && m_mw == 0 && cyc >= m_ready) begin
                if (w == 2'b01) m_x++;
                else if (w == 2'b10) m_o++;
                else m_d = (m_d < 9) ? m_d + 1 : 9;
                if (m_x == TARGET) m_mw = 1;
                else if (m_o == TARGET) m_mw = 2;
                else begin
                    m_ready  = cyc + HOLD + 1;
                    m_ng_due = cyc + HOLD;
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_score();
        return 16'(m_mw * 4096 + m_d * 256 + m_o * 16 + m_x);
    endfunction

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic tick(input logic [1:0] w, input logic c);
        winner = w;
        clear  = c;
        model_step(w, c);
        @(posedge clk);
        #1;
        cyc++;
        if (new_game === 1'b1) ng_seen++;
    endtask

    task automatic play_game(input logic [1:0] w);
        tick(w, 1'b0);
        repeat (HOLD + 2) tick(2'b00, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; winner = 2'b01; clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (score_data !== 16'h0000) $display("FAIL reset_score: got %h want %h", score_data, 16'h0000); else n_pass++;
        n_checks++; if (match_over !== 1'b0) $display("FAIL reset_match_over: got %b want 0", match_over); else n_pass++;
        n_checks++; if (new_game !== 1'b0) $display("FAIL reset_new_game: got %b want 0", new_game); else n_pass++;
        n_checks++; if (match_winner !== 2'b00) $display("FAIL reset_match_winner: got %b want 00", match_winner); else n_pass++;
        @(negedge clk);
        winner = 2'b00;
        reset  = 1'b1;
        ng_seen = 0;
        repeat (3) tick(2'b00, 1'b0);
        n_checks++; if (ng_seen !== 0) $display("FAIL reset_release_pulse: got %0d pulses want 0", ng_seen); else n_pass++;
        n_checks++; if (score_data !== 16'h0000) $display("FAIL reset_release_score: got %h want %h", score_data, 16'h0000); else n_pass++;
    endtask

    task automatic test_single_win();
        int first_ng;
        first_ng = -1;
        ng_seen  = 0;
        tick(2'b01, 1'b0);
        n_checks++; if (score_data !== 16'h0001) $display("FAIL single_score: got %h want %h", score_data, 16'h0001); else n_pass++;
        for (int i = 1; i <= 9; i++) begin
            tick(2'b01, 1'b0);
            if (new_game === 1'b1 && first_ng < 0) first_ng = i;
        end
        n_checks++; if (ng_seen !== 1) $display("FAIL single_pulse_count: got %0d want 1", ng_seen); else n_pass++;
        n_checks++; if (first_ng !== HOLD) $display("FAIL single_pulse_time: got %0d want %0d", first_ng, HOLD); else n_pass++;
        n_checks++; if (score_data !== 16'h0001) $display("FAIL single_no_recount: got %h want %h", score_data, 16'h0001); else n_pass++;
        n_checks++; if (score_data !== exp_score()) $display("FAIL single_model: got %h want %h", score_data, exp_score()); else n_pass++;
        tick(2'b00, 1'b0);
    endtask

    task automatic test_match_end();
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b0);
        play_game(2'b01);
        play_game(2'b11);
        play_game(2'b01);
        ng_seen = 0;
        play_game(2'b01);
        n_checks++; if (score_data !== 16'h1103) $display("FAIL match_score: got %h want %h", score_data, 16'h1103); else n_pass++;
        n_checks++; if (match_over !== 1'b1) $display("FAIL match_over: got %b want 1", match_over); else n_pass++;
        n_checks++; if (match_winner !== 2'b01) $display("FAIL match_winner: got %b want 01", match_winner); else n_pass++;
        n_checks++; if (ng_seen !== 0) $display("FAIL match_no_new_game: got %0d pulses want 0", ng_seen); else n_pass++;
        n_checks++; if (score_data !== exp_score()) $display("FAIL match_model: got %h want %h", score_data, exp_score()); else n_pass++;
    endtask

    task automatic test_draw_saturation();
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b0);
        for (int g = 1; g <= 10; g++) begin
            play_game(2'b11);
            if (g >= 9) begin
                n_checks++; if (score_data !== 16'h0900) $display("FAIL draw_sat_%0d: got %h want %h", g, score_data, 16'h0900); else n_pass++;
            end
            n_checks++; if (score_data !== exp_score()) $display("FAIL draw_model_%0d: got %h want %h", g, score_data, exp_score()); else n_pass++;
        end
    endtask

    task automatic test_clear_priority();
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b0);
        tick(2'b10, 1'b1);
        n_checks++; if (score_data !== 16'h0000) $display("FAIL clrpri_score: got %h want %h", score_data, 16'h0000); else n_pass++;
        n_checks++; if (new_game !== 1'b1) $display("FAIL clrpri_pulse: got %b want 1", new_game); else n_pass++;
        tick(2'b10, 1'b0);
        n_checks++; if (new_game !== 1'b0) $display("FAIL clrpri_single_pulse: got %b want 0", new_game); else n_pass++;
        n_checks++; if (score_data !== 16'h0000) $display("FAIL clrpri_held_level: got %h want %h", score_data, 16'h0000); else n_pass++;
        tick(2'b00, 1'b0);
        repeat (TARGET) play_game(2'b10);
        n_checks++; if (score_data !== 16'h2030) $display("FAIL o_match_score: got %h want %h", score_data, 16'h2030); else n_pass++;
        n_checks++; if (match_winner !== 2'b10) $display("FAIL o_match_winner: got %b want 10", match_winner); else n_pass++;
        tick(2'b00, 1'b1);
        n_checks++; if (score_data !== 16'h0000) $display("FAIL clr_match_score: got %h want %h", score_data, 16'h0000); else n_pass++;
        n_checks++; if (new_game !== 1'b1) $display("FAIL clr_match_pulse: got %b want 1", new_game); else n_pass++;
        n_checks++; if (match_over !== 1'b0) $display("FAIL clr_match_over: got %b want 0", match_over); else n_pass++;
        tick(2'b00, 1'b0);
        n_checks++; if (new_game !== 1'b0) $display("FAIL clr_match_pulse_end: got %b want 0", new_game); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        tick(2'b01, 1'b0);
        tick(2'b00, 1'b0);
        tick(2'b00, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ng_seen = 0;
        repeat (HOLD + 5) tick(2'b00, 1'b0);
        n_checks++; if (ng_seen !== 0) $display("FAIL rst_hold_pulse: got %0d pulses want 0", ng_seen); else n_pass++;
        n_checks++; if (score_data !== 16'h0000) $display("FAIL rst_hold_score: got %h want %h", score_data, 16'h0000); else n_pass++;
        tick(2'b01, 1'b0);
        n_checks++; if (score_data !== 16'h0001) $display("FAIL rst_hold_play: got %h want %h", score_data, 16'h0001); else n_pass++;
        tick(2'b00, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] w;
        logic       c;
        tick(2'b00, 1'b1);
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            c = ($urandom_range(0, 59) == 0);
            tick(w, c);
            n_checks++; if (score_data !== exp_score()) $display("FAIL rand_score cyc %0d: got %h want %h", cyc, score_data, exp_score()); else n_pass++;
            n_checks++; if (new_game !== m_ng) $display("FAIL rand_new_game cyc %0d: got %b want %b", cyc, new_game, m_ng); else n_pass++;
            n_checks++; if (match_over !== (m_mw != 0)) $display("FAIL rand_match_over cyc %0d: got %b want %b", cyc, match_over, (m_mw != 0)); else n_pass++;
            n_checks++; if (match_winner !== 2'(m_mw)) $display("FAIL rand_match_winner cyc %0d: got %b want %b", cyc, match_winner, 2'(m_mw)); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_win();
        test_match_end();
        test_draw_saturation();
        test_clear_priority();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
